// File: rtl/fifo_buf_rd.sv
// +----------------------------------------------------------------------------+
// | Module   : fifo_buf_rd                                                     |
// | Desc     : FIFO storage with a two-state pop FSM; one word per 2 cycles.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_buf_rd #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              r_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0] c_FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_OUT  = 1'b1
  } rd_state_e;

  rd_state_e         state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic w_pop;
  logic w_wr_accept;

  assign full  = (count_q == c_FULL_CNT);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a write to a full FIFO may proceed.
  assign w_pop       = (state_q == RD_IDLE) && r_en && !empty;
  assign w_wr_accept = wr_ld && (!full || w_pop);

  always_comb begin
    count_d = count_q;
    case ({w_wr_accept, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_drop_q <= wr_ld && !w_wr_accept;
      if (w_wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      case (state_q)
        RD_IDLE: begin
          rd_valid_q <= 1'b0;
          if (w_pop) begin
            rd_data_q  <= mem_q[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            rd_valid_q <= 1'b1;
            state_q    <= RD_OUT;
          end
        end
        RD_OUT: begin
          rd_valid_q <= 1'b0;
          state_q    <= RD_IDLE;
        end
        default: begin
          rd_valid_q <= 1'b0;
          state_q    <= RD_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign wr_drop  = wr_drop_q;

endmodule

`default_nettype wire
